ps2_rx_frame: RTL

- PS/2 device-to-host receiver; sits directly upstream of the key identification stage.
- Samples raw ps2c/ps2d, debounces the PS/2 clock, detects falling edges and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Emits one-cycle rx_done_tick with the 8-bit scan code on dout; downstream FSM consumes both unchanged.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_rx_frame_if.sv | 10 +
 rtl/ps2_clk_filter.sv | 42 ++++
 rtl/ps2_rx_frame.sv | 115 +++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding, frame geometry, break code
// and the frame integrity rule used when PS2_PARITY_CHECK_EN is defined.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DPS  = 2'b01,
    ST_LOAD = 2'b10
  } ps2_state_e;

  localparam int         PS2_FRAME_BITS     = 11;
  localparam logic [7:0] PS2_BREAK_CODE     = 8'hF0;
  localparam int         PS2_TIMEOUT_CYCLES = 100000;

  // start low, stop high, data+parity carry an odd number of ones
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return !f[0] && f[PS2_FRAME_BITS-1] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Receiver-to-key-identification handshake: enable in, scan code + pulses out.
interface ps2_rx_frame_if;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;

  modport master (input rx_en, output rx_done_tick, dout, frame_err);
  modport slave  (output rx_en, input rx_done_tick, dout, frame_err);
endinterface

// File: rtl/ps2_clk_filter.sv
// Two-flop synchronisers for ps2c/ps2d plus a FILTER_LEN-sample debounce on
// ps2c; fall_edge pulses for one cycle when the filtered clock drops.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_sync,
  output logic fall_edge
);

  logic [1:0]            c_sync, d_sync;
  logic [FILTER_LEN-1:0] shreg;
  logic                  filt_q, filt_d;

  // idle PS/2 lines are high, so everything resets to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync <= '1;
      d_sync <= '1;
      shreg  <= '1;
      filt_q <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      shreg  <= {shreg[FILTER_LEN-2:0], c_sync[1]};
      filt_q <= filt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    if (&shreg)       filt_d = 1'b1;
    else if (~|shreg) filt_d = 1'b0;
  end

  assign fall_edge = filt_q & ~filt_d;
  assign ps2d_sync = d_sync[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver. Define PS2_PARITY_CHECK_EN to reject
// frames with a bad start/stop/odd-parity bit (frame_err instead of a tick).
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2c,
  input  logic           ps2d,
  ps2_rx_frame_if.master bus
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  ps2_state_e                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_d, shift_in;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic [7:0]                dout_q, dout_d;
  logic                      ok_q, ok_d;
  logic                      ps2d_s, fall_edge;
  logic                      tick, err;
  logic                      unused_bits;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .ps2d_sync (ps2d_s),
    .fall_edge (fall_edge)
  );

  // right shift, newest bit at MSB; the oldest bit falls off the end
  assign shift_in    = {ps2d_s, shift_q[PS2_FRAME_BITS-1:1]};
  assign unused_bits = shift_q[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tmo_q   <= '0;
      dout_q  <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tmo_q   <= tmo_d;
      dout_q  <= dout_d;
      ok_q    <= ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tmo_d   = tmo_q;
    dout_d  = dout_q;
    ok_d    = ok_q;
    tick    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall_edge && bus.rx_en) begin
          shift_d = shift_in;
          cnt_d   = 4'd9;
          tmo_d   = '0;
          state_d = ST_DPS;
        end
      end
      ST_DPS: begin
        if (fall_edge) begin
          shift_d = shift_in;
          tmo_d   = '0;
          if (cnt_q == 4'd0) begin
            // judge and publish on the stop-bit edge so dout is valid with the tick
`ifdef PS2_PARITY_CHECK_EN
            ok_d = ps2_frame_ok(shift_in);
`else
            ok_d = 1'b1;
`endif
            if (ok_d) dout_d = shift_in[8:1];
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_LOAD: begin
        tick = ok_q;
`ifdef PS2_PARITY_CHECK_EN
        err = ~ok_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rx_done_tick = tick;
  assign bus.frame_err    = err;
  assign bus.dout         = dout_q;

endmodule
